// File: rtl/mem_rd_arbiter_if.sv
// Read-port bundle between the IFU/MEM requesters, the arbiter and the RAM read port.
// slave = arbiter side, master = requesters/RAM environment side.
interface mem_rd_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_data;
    logic          ex_req;
    logic [AW-1:0] ex_addr;
    logic          ex_done;
    logic [DW-1:0] ex_data;
    logic          ram_rd_req;
    logic [AW-1:0] ram_rd_addr;
    logic          ram_rd_fin;
    logic [DW-1:0] ram_rd_data;
    logic          grant;
    logic          busy;
    logic          rd_err;

    modport slave (
        input  if_req, if_addr, ex_req, ex_addr, ram_rd_fin, ram_rd_data,
        output if_done, if_data, ex_done, ex_data, ram_rd_req, ram_rd_addr,
               grant, busy, rd_err
    );

    modport master (
        output if_req, if_addr, ex_req, ex_addr, ram_rd_fin, ram_rd_data,
        input  if_done, if_data, ex_done, ex_data, ram_rd_req, ram_rd_addr,
               grant, busy, rd_err
    );
endinterface

// File: rtl/mem_rd_arbiter.sv
// Round-robin, single-outstanding RAM read arbiter for fetch (grant 0) and execute loads (grant 1).
// Define MEM_RD_ARB_TIMEOUT_EN to abort a REQ phase after TIMEOUT cycles with rd_err.
module mem_rd_arbiter #(
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    mem_rd_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state, state_d;
    logic          last_grant, last_grant_d;
    logic          grant_q, grant_d;
    logic          req_q, req_d;
    logic          if_done_q, if_done_d;
    logic          ex_done_q, ex_done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] if_data_q, if_data_d;
    logic [DW-1:0] ex_data_q, ex_data_d;
    logic          winner;
    logic          tmo;

`ifdef MEM_RD_ARB_TIMEOUT_EN
    localparam int CLW = $clog2(TIMEOUT + 1);
    localparam int CW  = (CLW < 8) ? 8 : ((CLW > 32) ? 32 : CLW);
    logic [CW-1:0] cnt_q, cnt_d;

    // Count holds the number of REQ cycles already spent without a fin.
    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        grant_d      = grant_q;
        addr_d       = addr_q;
        if_data_d    = if_data_q;
        ex_data_d    = ex_data_q;
        req_d        = 1'b0;
        if_done_d    = 1'b0;
        ex_done_d    = 1'b0;
        busy_d       = 1'b0;
        err_d        = 1'b0;
        winner       = 1'b0;
`ifdef MEM_RD_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state)
            IDLE: begin
                if (bus.if_req || bus.ex_req) begin
                    // Round-robin state only advances on a real conflict.
                    if (bus.if_req && bus.ex_req) begin
                        winner       = ~last_grant;
                        last_grant_d = ~last_grant;
                    end else begin
                        winner = bus.ex_req;
                    end
                    grant_d = winner;
                    addr_d  = winner ? bus.ex_addr : bus.if_addr;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = REQ;
`ifdef MEM_RD_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                busy_d = 1'b1;
                if (bus.ram_rd_fin) begin
                    if (grant_q) ex_data_d = bus.ram_rd_data;
                    else         if_data_d = bus.ram_rd_data;
                    if_done_d = ~grant_q;
                    ex_done_d = grant_q;
                    state_d   = RESP;
                end else if (tmo) begin
                    if_done_d = ~grant_q;
                    ex_done_d = grant_q;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end else begin
                    req_d = 1'b1;
`ifdef MEM_RD_ARB_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            req_q      <= 1'b0;
            if_done_q  <= 1'b0;
            ex_done_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            if_data_q  <= '0;
            ex_data_q  <= '0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            grant_q    <= grant_d;
            req_q      <= req_d;
            if_done_q  <= if_done_d;
            ex_done_q  <= ex_done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            if_data_q  <= if_data_d;
            ex_data_q  <= ex_data_d;
        end
    end

    assign bus.ram_rd_req  = req_q;
    assign bus.ram_rd_addr = addr_q;
    assign bus.if_done     = if_done_q;
    assign bus.ex_done     = ex_done_q;
    assign bus.if_data     = if_data_q;
    assign bus.ex_data     = ex_data_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = busy_q;
    assign bus.rd_err      = err_q;
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed-vector bench for mem_rd_arbiter; expected values are hand-derived per cycle.
module tb_mem_rd_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
`ifdef MEM_RD_ARB_TIMEOUT_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 5;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_rd_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_rd_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;
    logic [63:0] ife = '0;
    logic [63:0] exe = '0;
    logic own;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        bus.if_req = 0; bus.if_addr = '0; bus.ex_req = 0; bus.ex_addr = '0;
        bus.ram_rd_fin = 0; bus.ram_rd_data = '0;
        #12;
        chk("rst_req",   bus.ram_rd_req, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_addr",  bus.ram_rd_addr, 0);
        chk("rst_done",  {bus.if_done, bus.ex_done, bus.rd_err}, 0);
        tick; rst = 1'b1;

        // single fetch, fin in first REQ cycle
        bus.if_addr = 64'h8000_0000; bus.if_req = 1;
        tick;
        chk("t1_req",   bus.ram_rd_req, 1);
        chk("t1_addr",  bus.ram_rd_addr, 64'h8000_0000);
        chk("t1_grant", bus.grant, 0);
        chk("t1_busy",  bus.busy, 1);
        bus.ram_rd_fin = 1; bus.ram_rd_data = 64'h413;
        tick;
        bus.ram_rd_fin = 0; bus.if_req = 0;
        chk("t1_done",  bus.if_done, 1);
        chk("t1_data",  bus.if_data, 64'h413);
        chk("t1_exd",   bus.ex_done, 0);
        chk("t1_req0",  bus.ram_rd_req, 0);
        chk("t1_busyr", bus.busy, 1);
        ife = 64'h413;
        tick;
        chk("t1_done0", bus.if_done, 0);
        chk("t1_idle",  bus.busy, 0);

        // conflict round-robin, requests held, fin in 2nd REQ cycle
        bus.if_addr = 64'h1000; bus.ex_addr = 64'h2000;
        bus.if_req = 1; bus.ex_req = 1;
        for (int k = 0; k < 3; k++) begin
            own = (k == 1);
            tick;
            chk("rr_grant", bus.grant, own);
            chk("rr_addr",  bus.ram_rd_addr, own ? 64'h2000 : 64'h1000);
            chk("rr_req",   bus.ram_rd_req, 1);
            tick;
            chk("rr_req2",  bus.ram_rd_req, 1);
            bus.ram_rd_fin = 1; bus.ram_rd_data = 64'hA0 + k;
            tick;
            bus.ram_rd_fin = 0;
            if (own) exe = 64'hA0 + k; else ife = 64'hA0 + k;
            chk("rr_ifd",   bus.if_done, !own);
            chk("rr_exd",   bus.ex_done, own);
            chk("rr_ifdat", bus.if_data, ife);
            chk("rr_exdat", bus.ex_data, exe);
            if (k == 2) begin bus.if_req = 0; bus.ex_req = 0; end
            tick;
            chk("rr_pulse", {bus.if_done, bus.ex_done}, 0);
        end
        tick;
        chk("rr_idle", bus.busy, 0);

        // held address while requester changes inputs
        bus.ex_addr = 64'h8000_1008; bus.ex_req = 1;
        tick;
        bus.ex_addr = '0; bus.ex_req = 0;
        for (int i = 0; i < HOLD; i++) begin
            chk("ha_req",  bus.ram_rd_req, 1);
            chk("ha_addr", bus.ram_rd_addr, 64'h8000_1008);
            if (i == HOLD - 1) begin bus.ram_rd_fin = 1; bus.ram_rd_data = 64'h5555_AAAA; end
            tick;
        end
        bus.ram_rd_fin = 0;
        exe = 64'h5555_AAAA;
        chk("ha_done", bus.ex_done, 1);
        chk("ha_data", bus.ex_data, exe);
        chk("ha_ifd",  bus.if_data, ife);
        chk("ha_err",  bus.rd_err, 0);
        tick;
        chk("ha_done0", bus.ex_done, 0);

        // spurious fin in IDLE
        bus.ram_rd_fin = 1; bus.ram_rd_data = 64'hDEAD;
        tick;
        bus.ram_rd_fin = 0;
        chk("sp_done",  {bus.if_done, bus.ex_done}, 0);
        chk("sp_busy",  bus.busy, 0);
        tick;
        chk("sp_ifd",   bus.if_data, ife);
        chk("sp_exd",   bus.ex_data, exe);
        chk("sp_done2", {bus.if_done, bus.ex_done}, 0);

        // RAM never responds
        bus.ex_addr = 64'h3000; bus.ex_req = 1;
        tick;
        bus.ex_req = 0;
`ifdef MEM_RD_ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            chk("to_req", bus.ram_rd_req, 1);
            tick;
        end
        chk("to_req0", bus.ram_rd_req, 0);
        chk("to_done", bus.ex_done, 1);
        chk("to_err",  bus.rd_err, 1);
        chk("to_data", bus.ex_data, exe);
        tick;
        chk("to_err0", {bus.ex_done, bus.rd_err, bus.busy}, 0);
`else
        for (int i = 0; i < 10; i++) begin
            chk("nt_req", bus.ram_rd_req, 1);
            chk("nt_err", bus.rd_err, 0);
            tick;
        end
        bus.ram_rd_fin = 1; bus.ram_rd_data = 64'h77;
        tick;
        bus.ram_rd_fin = 0;
        exe = 64'h77;
        chk("nt_done", bus.ex_done, 1);
        chk("nt_data", bus.ex_data, exe);
        chk("nt_err2", bus.rd_err, 0);
        tick;
`endif

        // reset during 3rd REQ cycle
        bus.if_addr = 64'h4000; bus.if_req = 1;
        tick; tick; tick;
        chk("rm_req", bus.ram_rd_req, 1);
        rst = 1'b0;
        #1;
        chk("rm_req0",  bus.ram_rd_req, 0);
        chk("rm_busy",  bus.busy, 0);
        chk("rm_addr",  bus.ram_rd_addr, 0);
        chk("rm_data",  {bus.if_data, bus.ex_data}, 0);
        bus.if_req = 0;
        tick;
        rst = 1'b1;
        ife = '0; exe = '0;
        tick;
        chk("rm_nodone", {bus.if_done, bus.ex_done}, 0);

        bus.if_addr = 64'h5000; bus.if_req = 1;
        tick;
        chk("rm_grant", bus.grant, 0);
        chk("rm_addr2", bus.ram_rd_addr, 64'h5000);
        bus.ram_rd_fin = 1; bus.ram_rd_data = 64'h99;
        tick;
        bus.ram_rd_fin = 0; bus.if_req = 0;
        chk("rm_done", bus.if_done, 1);
        chk("rm_ifd",  bus.if_data, 64'h99);
        tick;

        // first conflict after reset goes to fetch
        bus.if_addr = 64'h6000; bus.ex_addr = 64'h7000;
        bus.if_req = 1; bus.ex_req = 1;
        tick;
        chk("rc_grant", bus.grant, 0);
        chk("rc_addr",  bus.ram_rd_addr, 64'h6000);
        bus.if_req = 0;
        bus.ram_rd_fin = 1; bus.ram_rd_data = 64'h1234;
        tick;
        bus.ram_rd_fin = 0; bus.ex_req = 0;
        chk("rc_done", {bus.if_done, bus.ex_done}, 2'b10);
        chk("rc_ifd",  bus.if_data, 64'h1234);
        tick;
        chk("rc_idle", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter

Two-requester read arbiter sharing the single RAM read port between instruction fetch (IFU) and execute-stage loads (MEM). It sits between the IFU/MEM read handshakes and the external RAM read interface of `top`. It replaces the fixed-priority read path with a registered, round-robin, single-outstanding sequencer that has a deterministic handshake.

## Interface
- `AW`, 64: address width.
- `DW`, 64: data width.
- `TIMEOUT`, 255: cycles in REQ before abort (used only with `MEM_RD_ARB_TIMEOUT_EN`); must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `if_req`  in  1  fetch read request; level, held until `if_done`.
- `if_addr`  in  AW  fetch address; stable while `if_req` is high.
- `if_done`  out  1  one-cycle completion pulse for fetch.
- `if_data`  out  DW  fetch read data; valid when `if_done` is high, held until the next fetch completion.
- `ex_req`, `ex_addr`, `ex_done`, `ex_data`: same as the fetch ports, for the execute load.
- `ram_rd_req`  out  1  RAM read request; held until `ram_rd_fin`.
- `ram_rd_addr`  out  AW  RAM read address; constant while `ram_rd_req` is high.
- `ram_rd_fin`  in  1  RAM completion pulse; `ram_rd_data` is valid in the same cycle.
- `ram_rd_data`  in  DW  RAM read data.
- `grant`  out  1  current or last owner: 0 = fetch, 1 = execute.
- `busy`  out  1  high in REQ and RESP.
- `rd_err`  out  1  timeout flag; pulses with `done`.

## Operation
- FSM states: IDLE, REQ, RESP. All outputs are registered.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester that is not `last_grant`, then set `last_grant` to the winner.
  - On grant: latch the owner's address into `ram_rd_addr`, set `grant`, go to REQ.
- **REQ**
  - `ram_rd_req` = 1.
  - On `ram_rd_fin`: capture `ram_rd_data` into the owner's data register and go to RESP.
  - Requester inputs are ignored here. A requester dropping `req` does not cancel the transaction.
- **RESP**
  - The owner's `done` = 1 for exactly this cycle. Next state is IDLE.
  - The requester must deassert `req` by the edge that ends RESP. A `req` seen high in IDLE is a new request.
- `ram_rd_fin` in IDLE or RESP is ignored.
- The non-owner data register is never modified.
- Reset values:
  - FSM = IDLE.
  - `ram_rd_req`, `if_done`, `ex_done`, `busy`, `rd_err` = 0.
  - `ram_rd_addr`, `if_data`, `ex_data` = 0.
  - `grant` = 0.
  - `last_grant` = 1, so fetch wins the first conflict.
- Reset mid-transaction: all outputs drop to reset values immediately (asynchronous). No `done` is issued.

## Timing
- Request sampled at edge 0 in IDLE → `ram_rd_req` high in cycle 1.
- `ram_rd_fin` in cycle n (n ≥ 1) → `done` in cycle n+1 → IDLE in cycle n+2.
- Minimum latency: `req` high before edge 0 → `done` in cycle 2. Back-to-back grants occur every 3 cycles minimum.
- `ram_rd_fin` in the first REQ cycle is legal.
- `busy` is high from cycle 1 through the RESP cycle inclusive.

## Configuration
- `MEM_RD_ARB_TIMEOUT_EN` defined:
  - An 8..32-bit counter clears on entering REQ and increments each REQ cycle without `ram_rd_fin`.
  - When the count reaches `TIMEOUT`: drop `ram_rd_req` and go to RESP with `done` = 1 and `rd_err` = 1. The owner's data register is unchanged.
  - `ram_rd_fin` in the same cycle as the timeout takes priority: normal completion, `rd_err` = 0.
- `MEM_RD_ARB_TIMEOUT_EN` undefined:
  - No counter; REQ waits indefinitely.
  - `rd_err` is tied to 0.

## Test plan
- **Single fetch.** `if_req` with `if_addr` = 0x80000000; RAM returns `ram_rd_fin` in cycle 1 with data 0x00000413.
  → `ram_rd_addr` = 0x80000000 in cycle 1, `if_done` pulse in cycle 2, `if_data` = 0x413, `ex_done` stays 0.
- **Conflict round-robin.** `if_req` and `ex_req` raised together and held; each RAM read completes after 2 cycles.
  → Grants are fetch, then execute, then fetch.
  → `ram_rd_addr` alternates between the two addresses.
  → Each `done` is exactly one cycle long.
- **Held address.** `ex_req` with `ex_addr` = 0x80001008; `ex_addr` is changed to 0x0 during REQ; `ram_rd_fin` arrives after 5 cycles.
  → `ram_rd_addr` stays 0x80001008 for all REQ cycles.
  → `ex_data` = `ram_rd_data`.
- **Reset mid-REQ.** `rst` low in the 3rd REQ cycle.
  → `ram_rd_req` = 0 in the same cycle.
  → No `done`.
  → After release, a new `if_req` is served normally, and fetch wins the first conflict.
- **Timeout (macro on, `TIMEOUT` = 4).** Execute request; RAM never responds.
  → `ram_rd_req` is high for 4 cycles.
  → `ex_done` = 1 and `rd_err` = 1 in the next cycle.
  → `ex_data` is unchanged.
  → With the macro off, `ram_rd_req` stays high and `rd_err` stays 0.
- **Spurious fin.** `ram_rd_fin` = 1 in IDLE with `ram_rd_data` = 0xDEAD.
  → No `done`; `if_data` and `ex_data` are unchanged.
